cmp_ramp_source: RTL and testbench

Source end of the 20-bit compare path. Generates a registered ramp (Ramp_out) and a registered threshold (Thresh_out) that drive the A and B inputs of the 20-bit comparator. The comparator's result comes back two clocks later and sets output duty, so this block updates period and threshold only at ramp wrap to avoid glitched cycles. Software writes new period/threshold through a valid/ready handshake into a shadow pair; the shadow pair is applied at the next wrap.

---
 rtl/cmp_ramp_source.sv | 111 +++++++++++
 tb/tb_cmp_ramp_source.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_ramp_source.sv
// Ramp / threshold source for the 20-bit compare path.
// The active period and threshold change only at ramp wrap, or immediately
// while the ramp is paused, so the comparator never sees a torn cycle.
// New settings arrive through a one-deep valid/ready shadow register.
module cmp_ramp_source #(
  parameter int unsigned WIDTH          = 20,
  parameter int unsigned DEFAULT_PERIOD = 1000,
  parameter int unsigned DEFAULT_THRESH = 500
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic [WIDTH-1:0] cfg_thresh_i,
  output logic [WIDTH-1:0] ramp_o,
  output logic [WIDTH-1:0] thresh_o,
  output logic             wrap_pulse_o,
  output logic             cfg_pending_o
);

  localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] DEF_THRESH = WIDTH'(DEFAULT_THRESH);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] ramp_q,     ramp_d;
  logic [WIDTH-1:0] thresh_q,   thresh_d;
  logic [WIDTH-1:0] period_q,   period_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [WIDTH-1:0] sh_thresh_q, sh_thresh_d;
  logic             pending_q,  pending_d;
  logic             ready_q,    ready_d;
  logic             wrap_q,     wrap_d;

  logic [WIDTH-1:0] period_eff;
  logic [WIDTH-1:0] ramp_last;
  logic             at_wrap;
  logic             take_cfg;
  logic             apply_cfg;

  // Period 0 behaves as period 1; the wrap test uses >= so that a period
  // shrunk while paused still wraps on the first enabled edge.
  always_comb begin
    period_eff = (period_q == '0) ? ONE : period_q;
    ramp_last  = period_eff - ONE;
    at_wrap    = enable_i && (ramp_q >= ramp_last);
    take_cfg   = cfg_valid_i && !pending_q;
    apply_cfg  = pending_q && (at_wrap || !enable_i);
  end

  // Next-state: ramp advance, shadow capture and shadow apply.
  always_comb begin
    ramp_d      = ramp_q;
    thresh_d    = thresh_q;
    period_d    = period_q;
    sh_period_d = sh_period_q;
    sh_thresh_d = sh_thresh_q;
    pending_d   = pending_q;
    wrap_d      = at_wrap;

    if (enable_i) begin
      ramp_d = at_wrap ? '0 : ramp_q + ONE;
    end

    // Capture and apply are mutually exclusive: one needs the shadow empty,
    // the other needs it full. A capture on a wrap edge therefore waits for
    // the following wrap.
    if (apply_cfg) begin
      period_d  = sh_period_q;
      thresh_d  = sh_thresh_q;
      pending_d = 1'b0;
    end else if (take_cfg) begin
      sh_period_d = cfg_period_i;
      sh_thresh_d = cfg_thresh_i;
      pending_d   = 1'b1;
    end

    ready_d = !pending_d;
  end

  // State registers; reset restarts the ramp and discards any pending config.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ramp_q      <= '0;
      thresh_q    <= DEF_THRESH;
      period_q    <= DEF_PERIOD;
      sh_period_q <= '0;
      sh_thresh_q <= '0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b1;
      wrap_q      <= 1'b0;
    end else begin
      ramp_q      <= ramp_d;
      thresh_q    <= thresh_d;
      period_q    <= period_d;
      sh_period_q <= sh_period_d;
      sh_thresh_q <= sh_thresh_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      wrap_q      <= wrap_d;
    end
  end

  assign ramp_o        = ramp_q;
  assign thresh_o      = thresh_q;
  assign wrap_pulse_o  = wrap_q;
  assign cfg_pending_o = pending_q;
  assign cfg_ready_o   = ready_q;

endmodule

// File: tb/tb_cmp_ramp_source.sv
// Testbench for cmp_ramp_source: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_cmp_ramp_source;

  localparam int W = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_period = '0;
  logic [W-1:0]  cfg_thresh = '0;
  logic [W-1:0]  ramp;
  logic [W-1:0]  thresh;
  logic          wrap_pulse;
  logic          cfg_pending;

  cmp_ramp_source #(.WIDTH(W), .DEFAULT_PERIOD(1000), .DEFAULT_THRESH(500)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_period_i (cfg_period),
    .cfg_thresh_i (cfg_thresh),
    .ramp_o       (ramp),
    .thresh_o     (thresh),
    .wrap_pulse_o (wrap_pulse),
    .cfg_pending_o(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int t; } cfg_t;

  // Reference model state
  int   m_ramp, m_period, m_thresh;
  bit   m_pulse;
  cfg_t shadow[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ramp   = 0;
    m_period = 1000;
    m_thresh = 500;
    m_pulse  = 0;
    shadow.delete();
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(bit en, bit v, int p, int t);
    int   pe;
    bit   wrapped;
    cfg_t c;
    pe      = (m_period == 0) ? 1 : m_period;
    wrapped = en && (m_ramp >= pe - 1);
    if (en) m_ramp = wrapped ? 0 : m_ramp + 1;
    m_pulse = wrapped;
    if (shadow.size() != 0 && (wrapped || !en)) begin
      c = shadow.pop_front();
      m_period = c.p;
      m_thresh = c.t;
    end else if (v && shadow.size() == 0) begin
      c.p = p;
      c.t = t;
      shadow.push_back(c);
    end
  endtask

  task automatic check_all();
    chk("ramp",    int'(ramp),    m_ramp);
    chk("thresh",  int'(thresh),  m_thresh);
    chk("pulse",   int'(wrap_pulse), int'(m_pulse));
    chk("pending", int'(cfg_pending), (shadow.size() != 0) ? 1 : 0);
    chk("ready",   int'(cfg_ready),   (shadow.size() == 0) ? 1 : 0);
  endtask

  task automatic cyc(bit en, bit v, int p, int t);
    enable     = en;
    cfg_valid  = v;
    cfg_period = W'(p);
    cfg_thresh = W'(t);
    @(posedge clk);
    model_step(en, v, p, t);
    @(negedge clk);
    check_all();
  endtask

  // Idle-run until the ramp is at target before the next edge.
  task automatic run_to(int target);
    for (int i = 0; i < 3000; i++) begin
      if (m_ramp == target) break;
      cyc(1, 0, 0, 0);
    end
    chk("reach_ramp", int'(ramp), target);
  endtask

  // Run until the pending config has been applied.
  task automatic wait_apply();
    for (int i = 0; i < 3000; i++) begin
      if (shadow.size() == 0) break;
      cyc(1, 0, 0, 0);
    end
    chk("applied", int'(cfg_pending), 0);
  endtask

  // Called in a pulse cycle: counts clocks to the next pulse from the DUT.
  task automatic measure(int exp);
    int n;
    n = 0;
    do begin
      cyc(1, 0, 0, 0);
      n++;
    end while (!wrap_pulse && n < 3000);
    chk("period_len", n, exp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ramp",    int'(ramp), 0);
    chk("rst_thresh",  int'(thresh), 500);
    chk("rst_pending", int'(cfg_pending), 0);
    chk("rst_ready",   int'(cfg_ready), 1);
    chk("rst_pulse",   int'(wrap_pulse), 0);
    rst_n = 1'b1;

    // Default 1000-clock ramp, threshold 500
    run_to(999);
    cyc(1, 0, 0, 0);
    chk("s1_pulse", int'(wrap_pulse), 1);
    measure(1000);
    chk("s1_thresh", int'(thresh), 500);

    // Mid-period offer, applied at the wrap after 999
    run_to(300);
    cyc(1, 1, 10, 4);
    chk("s2_pending", int'(cfg_pending), 1);
    run_to(999);
    cyc(1, 0, 0, 0);
    chk("s2_thresh", int'(thresh), 4);
    chk("s2_pulse",  int'(wrap_pulse), 1);
    measure(10);

    // Offers while pending are ignored; re-offer after ready returns
    cyc(1, 1, 7, 3);
    repeat (3) cyc(1, 1, 20, 9);
    wait_apply();
    chk("s3_thresh", int'(thresh), 3);
    measure(7);
    cyc(1, 1, 20, 8);
    wait_apply();
    chk("s3_thresh2", int'(thresh), 8);
    measure(20);

    // Transfer on the exact wrap edge takes effect one period later
    cyc(1, 1, 10, 4);
    wait_apply();
    run_to(9);
    cyc(1, 1, 5, 2);
    chk("s4_pulse",   int'(wrap_pulse), 1);
    chk("s4_pending", int'(cfg_pending), 1);
    measure(10);
    measure(5);

    // Apply while paused, then wrap immediately on re-enable
    cyc(1, 1, 12, 6);
    wait_apply();
    run_to(7);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 3, 2);
    chk("s5_pending", int'(cfg_pending), 1);
    cyc(0, 0, 0, 0);
    chk("s5_thresh", int'(thresh), 2);
    chk("s5_hold",   int'(ramp), 7);
    cyc(1, 0, 0, 0);
    chk("s5_ramp0",  int'(ramp), 0);
    chk("s5_pulse",  int'(wrap_pulse), 1);
    measure(3);

    // Asynchronous reset with a config pending
    cyc(1, 1, 50, 25);
    repeat (3) cyc(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_ramp",    int'(ramp), 0);
    chk("s6_thresh",  int'(thresh), 500);
    chk("s6_pending", int'(cfg_pending), 0);
    chk("s6_ready",   int'(cfg_ready), 1);
    chk("s6_pulse",   int'(wrap_pulse), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_to(999);
    cyc(1, 0, 0, 0);
    chk("s6_pulse2", int'(wrap_pulse), 1);
    measure(1000);

    // Random traffic with small periods, including 0 and 1
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(99) < 85) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 25) ? 1'b1 : 1'b0,
          int'($urandom_range(12)),
          int'($urandom_range(15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
